// File: rtl/edu_tpu_wb_array.sv
// edu_tpu_wb_array: Wishbone-mapped N x N weight-stationary int8 systolic array with input/result FIFOs.
// Optional build macro RELU_EN clamps negative results to zero before they enter the result FIFO.
module edu_tpu_wb_array #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N            = 3,
  parameter int          DEPTH        = 8,
  parameter int          ACC_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        irq_o
);
  localparam int DATA_W   = 8;
  localparam int COEF_W   = 8;
  localparam int STAGES   = 2 * N;
  localparam int VEC_W    = DATA_W * N;
  localparam int RES_SIZE = DEPTH * N;
  localparam int IPW      = $clog2(DEPTH);
  localparam int RPW      = $clog2(RES_SIZE + 1);
  localparam int RW       = $clog2(N);
  localparam int DW       = $clog2(STAGES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [COEF_W-1:0] w,
                                                        input logic signed [DATA_W-1:0] x);
    logic signed [COEF_W+DATA_W-1:0] p;
    p = w * x;
    return ACC_W'(p);
  endfunction

  function automatic logic signed [ACC_W-1:0] post_proc(input logic signed [ACC_W-1:0] y);
`ifdef RELU_EN
    return (y < 0) ? '0 : y;
`else
    return y;
`endif
  endfunction

  function automatic logic [RPW-1:0] rwrap(input int v);
    return RPW'((v >= RES_SIZE) ? v - RES_SIZE : v);
  endfunction

  state_t                   state;
  logic [DW-1:0]            drain_cnt;
  logic [STAGES-1:0]        vld_p;
  logic [RW-1:0]            row;
  logic signed [COEF_W-1:0] w_q [N][N];
  logic [VEC_W-1:0]         in_mem [DEPTH];
  logic [IPW-1:0]           in_wr, in_rd;
  logic [IPW:0]             in_cnt;
  logic signed [ACC_W-1:0]  res_mem [RES_SIZE];
  logic [RPW-1:0]           res_wr, res_rd, res_cnt;
  logic                     overflow, underflow, busy_err;

  logic [31:0] offs, status, rdata;
  logic        hit, acc, wr, rd, busy, clr, start;
  logic        sel_ctrl, sel_stat, sel_wgt, sel_in, sel_res;
  logic        wgt_wr, in_wr_req, in_full, in_push, pop;
  logic        res_rd_req, res_pop, res_fit, res_push;
  logic [VEC_W-1:0] in_head;
  logic        unused_bits;

  assign offs     = wb_adr_i - BASE_ADDRESS;
  assign hit      = wb_stb_i && wb_cyc_i && (offs < 32'd20);
  assign acc      = hit && !wb_ack_o;
  assign wr       = acc && wb_we_i;
  assign rd       = acc && !wb_we_i;
  assign sel_ctrl = (offs == 32'h00);
  assign sel_stat = (offs == 32'h04);
  assign sel_wgt  = (offs == 32'h08);
  assign sel_in   = (offs == 32'h0C);
  assign sel_res  = (offs == 32'h10);
  assign unused_bits = ^wb_dat_i;

  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign clr        = wr && sel_ctrl && wb_dat_i[1];
  assign start      = wr && sel_ctrl && wb_dat_i[0] && !clr && (state == S_IDLE || state == S_DONE);
  assign wgt_wr     = wr && sel_wgt && !busy;
  assign in_wr_req  = wr && sel_in && !busy;
  assign in_full    = (in_cnt == (IPW+1)'(DEPTH));
  assign in_push    = in_wr_req && !in_full;
  assign pop        = (state == S_RUN) && (in_cnt != '0);
  assign in_head    = in_mem[in_rd];
  assign res_rd_req = rd && sel_res;
  assign res_pop    = res_rd_req && (res_cnt != '0);
  assign res_fit    = (int'(res_cnt) + N) <= (RES_SIZE + int'(res_pop));
  assign res_push   = vld_p[STAGES-1] && res_fit;
  assign irq_o      = (state == S_DONE);

  assign status = {8'h00, 8'(res_cnt), 8'(in_cnt), 2'b00, busy_err, underflow, overflow,
                   in_full, irq_o, busy};

  always_comb begin
    rdata = '0;
    if (sel_stat) rdata = status;
    else if (sel_res && res_cnt != '0) rdata = 32'(res_mem[res_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= hit && !wb_ack_o;
      wb_dat_o <= rd ? rdata : '0;
    end
  end

  // Weights survive CLEAR; only rst zeroes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) w_q[i][j] <= '0;
    end else if (clr) begin
      row <= '0;
    end else if (wgt_wr) begin
      for (int j = 0; j < N; j++) w_q[row][j] <= $signed(wb_dat_i[DATA_W*j +: COEF_W]);
      row <= (row == RW'(N - 1)) ? '0 : row + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= wb_dat_i[VEC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      vld_p     <= '0;
      in_wr     <= '0;
      in_rd     <= '0;
      in_cnt    <= '0;
      res_wr    <= '0;
      res_rd    <= '0;
      res_cnt   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      busy_err  <= 1'b0;
    end else begin
      vld_p <= {vld_p[STAGES-2:0], pop};
      if (in_push) in_wr <= in_wr + IPW'(1);
      if (pop) in_rd <= in_rd + IPW'(1);
      in_cnt <= in_cnt + (IPW+1)'(in_push) - (IPW+1)'(pop);
      if (res_push) res_wr <= rwrap(int'(res_wr) + N);
      if (res_pop) res_rd <= rwrap(int'(res_rd) + 1);
      res_cnt <= res_cnt + (res_push ? RPW'(N) : '0) - RPW'(res_pop);
      if ((in_wr_req && in_full) || (vld_p[STAGES-1] && !res_fit)) overflow <= 1'b1;
      if (res_rd_req && res_cnt == '0) underflow <= 1'b1;
      if (wr && (sel_wgt || sel_in) && busy) busy_err <= 1'b1;
      case (state)
        S_IDLE, S_DONE: if (start) state <= S_RUN;
        S_RUN: begin
          if (in_cnt == '0) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DW'(STAGES - 2)) state <= S_DONE;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic signed [DATA_W-1:0] xsh_p0 [N][N];
  logic signed [DATA_W-1:0] x_p1   [N][N];
  logic signed [ACC_W-1:0]  ps_p1  [N][N];
  logic signed [ACC_W-1:0]  dsk_p2 [N][N-1];
  logic signed [DATA_W-1:0] x_in   [N][N];
  logic signed [ACC_W-1:0]  ps_in  [N][N];
  logic signed [ACC_W-1:0]  y_out  [N];

  always_comb begin
    for (int j = 0; j < N; j++) x_in[0][j] = xsh_p0[j][j];
    for (int i = 1; i < N; i++)
      for (int j = 0; j < N; j++) x_in[i][j] = x_p1[i-1][j];
    for (int i = 0; i < N; i++) ps_in[i][0] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 1; j < N; j++) ps_in[i][j] = ps_p1[i][j-1];
    for (int i = 0; i < N - 1; i++) y_out[i] = dsk_p2[i][N-2-i];
    y_out[N-1] = ps_p1[N-1][N-1];
  end

  // p0: column j sees the popped vector j cycles late
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) xsh_p0[0][j] <= $signed(in_head[DATA_W*j +: DATA_W]);
    for (int d = 1; d < N; d++)
      for (int j = 0; j < N; j++) xsh_p0[d][j] <= xsh_p0[d-1][j];
  end

  // p1: x flows down columns, partial sums flow along rows
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        x_p1[i][j]  <= x_in[i][j];
        ps_p1[i][j] <= ps_in[i][j] + mac_term(w_q[i][j], x_in[i][j]);
      end
  end

  // p2: row i is delayed N-1-i cycles so a whole vector lands together
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      dsk_p2[i][0] <= ps_p1[i][N-1];
      for (int d = 1; d < N - 1; d++) dsk_p2[i][d] <= dsk_p2[i][d-1];
    end
  end

  always_ff @(posedge clk) begin
    if (res_push)
      for (int i = 0; i < N; i++) res_mem[rwrap(int'(res_wr) + i)] <= post_proc(y_out[i]);
  end
endmodule

// File: tb/tb_edu_tpu_wb_array.sv
// Self-checking bench for edu_tpu_wb_array: N=3 instance with a behavioural model, plus an N=4 instance.
module tb_edu_tpu_wb_array;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int N = 3;
  localparam int DEPTH = 8;
  localparam logic [31:0] A_CTRL = BASE, A_STAT = BASE + 4, A_WGT = BASE + 8;
  localparam logic [31:0] A_IN = BASE + 12, A_RES = BASE + 16;

  logic clk = 1'b0;
  logic rst, stb, cyc, we, sel4;
  logic [31:0] adr, wdat;
  logic ack3, ack4, irq3, irq4, ack, irq;
  logic [31:0] rdat3, rdat4, rdat;

  always #5 clk = ~clk;

  edu_tpu_wb_array #(.N(3)) dut (
    .clk(clk), .rst(rst), .wb_stb_i(stb && !sel4), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_ack_o(ack3), .wb_dat_o(rdat3), .irq_o(irq3));

  edu_tpu_wb_array #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .wb_stb_i(stb && sel4), .wb_cyc_i(cyc), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_ack_o(ack4), .wb_dat_o(rdat4), .irq_o(irq4));

  assign ack  = sel4 ? ack4 : ack3;
  assign irq  = sel4 ? irq4 : irq3;
  assign rdat = sel4 ? rdat4 : rdat3;

  int checks = 0;
  int failures = 0;

  int mw [N][N];
  logic [31:0] in_q [$];
  int res_q [$];
  int mrow;

  typedef struct {
    logic [31:0] r0, r1, r2, x;
    int y0, y1, y2;
  } tv_t;
  tv_t tv [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sb(input logic [31:0] v, input int j);
    logic [7:0] b;
    b = v[8*j +: 8];
    return int'($signed(b));
  endfunction

  function automatic int post(input int y);
`ifdef RELU_EN
    return (y < 0) ? 0 : y;
`else
    return y;
`endif
  endfunction

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    adr = a; we = w; wdat = d; stb = 1'b1; cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    q = rdat;
    if (!ack) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: got no ack at addr %h", a);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, 1'b1, d, q);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    wb_xfer(a, 1'b0, 32'h0, q);
  endtask

  task automatic put_weight(input logic [31:0] word);
    wr(A_WGT, word);
    for (int j = 0; j < N; j++) mw[mrow][j] = sb(word, j);
    mrow = (mrow + 1) % N;
  endtask

  task automatic put_input(input logic [31:0] word);
    wr(A_IN, word);
    if (in_q.size() < DEPTH) in_q.push_back(word);
  endtask

  task automatic m_run();
    int y;
    foreach (in_q[k]) begin
      for (int i = 0; i < N; i++) begin
        y = 0;
        for (int j = 0; j < N; j++) y += mw[i][j] * sb(in_q[k], j);
        res_q.push_back(post(y));
      end
    end
    in_q.delete();
  endtask

  task automatic do_clear();
    wr(A_CTRL, 32'h2);
    mrow = 0;
    in_q.delete();
    res_q.delete();
  endtask

  task automatic do_start();
    wr(A_CTRL, 32'h1);
    m_run();
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!irq && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic drain_check(input string nm);
    logic [31:0] q, e;
    rd(A_STAT, q);
    chk({nm, "_res_count"}, 32'(q[23:16]), 32'(res_q.size()));
    while (res_q.size() > 0) begin
      rd(A_RES, q);
      e = res_q.pop_front();
      chk(nm, q, e);
    end
  endtask

  task automatic rand_weights();
    for (int r = 0; r < N; r++) put_weight($urandom);
  endtask

  initial begin
    logic [31:0] q;
    logic seen;
    int c, k;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel4 = 1'b0;
    adr = '0; wdat = '0; mrow = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mw[i][j] = 0;

    tv[0] = '{32'h000001, 32'h000100, 32'h010000, 32'h030201, 1, 2, 3};
    tv[1] = '{32'hFFFFFF, 32'hFFFFFF, 32'hFFFFFF, 32'h030201, -6, -6, -6};
    tv[2] = '{32'h040302, 32'h0100FF, 32'h7F7F7F, 32'h07FB0A, 33, -3, 1524};
    tv[3] = '{32'h808080, 32'h808080, 32'h808080, 32'h808080, 49152, 49152, 49152};
    tv[4] = '{32'h01807F, 32'h000000, 32'h050505, 32'hFF7F80, -32513, 0, -10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack3), 32'h0);
    chk("rst_dat", rdat3, 32'h0);
    chk("rst_irq", 32'(irq3), 32'h0);
    rst = 1'b0;
    rd(A_STAT, q);
    chk("rst_status", q, 32'h0);

    // Window decode: unmapped in-window reads give 0, outside the window no ack.
    rd(BASE + 32'h6, q);
    chk("unaligned_read", q, 32'h0);
    rd(A_CTRL, q);
    chk("ctrl_read", q, 32'h0);
    adr = BASE + 32'd20; we = 1'b0; stb = 1'b1; cyc = 1'b1; seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= ack; end
    adr = BASE - 32'd4;
    repeat (4) begin @(posedge clk); #1; seen |= ack; end
    stb = 1'b0; cyc = 1'b0;
    chk("out_of_window_ack", 32'(seen), 32'h0);

    // Identity weights, one vector.
    do_clear();
    put_weight(32'h000001); put_weight(32'h000100); put_weight(32'h010000);
    put_input(32'h030201);
    do_start();
    wait_done(c);
    chk("id_latency", c, 7);
    rd(A_STAT, q);
    chk("id_status_done", q, 32'h0003_0002);
    for (int i = 0; i < 3; i++) begin
      rd(A_RES, q);
      chk("id_result", q, 32'(i + 1));
    end
    rd(A_RES, q);
    chk("underflow_read", q, 32'h0);
    rd(A_STAT, q);
    chk("underflow_status", q, 32'h0000_0012);

    // Table of single-vector cases.
    for (int t = 0; t < 5; t++) begin
      do_clear();
      put_weight(tv[t].r0); put_weight(tv[t].r1); put_weight(tv[t].r2);
      put_input(tv[t].x);
      do_start();
      wait_done(c);
      chk($sformatf("tv%0d_latency", t), c, 7);
      rd(A_RES, q); chk($sformatf("tv%0d_y0", t), q, 32'(post(tv[t].y0)));
      rd(A_RES, q); chk($sformatf("tv%0d_y1", t), q, 32'(post(tv[t].y1)));
      rd(A_RES, q); chk($sformatf("tv%0d_y2", t), q, 32'(post(tv[t].y2)));
      res_q.delete();
    end

    // START with an empty FIFO.
    do_clear();
    do_start();
    wait_done(c);
    chk("k0_latency", c, 2 * N);
    rd(A_STAT, q);
    chk("k0_status", q, 32'h0000_0002);

    // Input FIFO overflow: 9 writes into DEPTH=8.
    do_clear();
    rand_weights();
    for (int i = 0; i < 9; i++) put_input($urandom);
    rd(A_STAT, q);
    chk("ovf_status", q, 32'h0000_080C);
    do_start();
    wait_done(c);
    chk("ovf_latency", c, 8 + 2 * N);
    rd(A_STAT, q);
    chk("ovf_done_status", q, 32'h0018_000A);
    drain_check("ovf_result");

    // Writes while busy are ignored and flagged.
    do_clear();
    rand_weights();
    for (int i = 0; i < 3; i++) put_input($urandom);
    do_start();
    wr(A_WGT, $urandom);
    wr(A_IN, $urandom);
    wait_done(c);
    rd(A_STAT, q);
    chk("busy_err_status", q, 32'h0009_0022);
    drain_check("busy_result");
    for (int i = 0; i < 2; i++) put_input($urandom);
    do_start();
    wait_done(c);
    drain_check("busy_weights_kept");

    // CLEAR during RUN.
    do_clear();
    rand_weights();
    for (int i = 0; i < 4; i++) put_input($urandom);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h3);
    mrow = 0; in_q.delete(); res_q.delete();
    repeat (12) @(posedge clk);
    #1;
    rd(A_STAT, q);
    chk("clear_mid_run_status", q, 32'h0);
    for (int i = 0; i < 2; i++) put_input($urandom);
    do_start();
    wait_done(c);
    chk("after_clear_latency", c, 2 + 2 * N);
    drain_check("after_clear_result");

    // rst during RUN.
    for (int i = 0; i < 4; i++) put_input($urandom);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mrow = 0; in_q.delete(); res_q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mw[i][j] = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mid_run_irq", 32'(irq3), 32'h0);
    rd(A_STAT, q);
    chk("rst_mid_run_status", q, 32'h0);
    rand_weights();
    for (int i = 0; i < 3; i++) put_input($urandom);
    do_start();
    wait_done(c);
    drain_check("after_rst_result");

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      rand_weights();
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) put_input($urandom);
      do_start();
      wait_done(c);
      chk($sformatf("rand%0d_latency", r), c, k + 2 * N);
      drain_check($sformatf("rand%0d_result", r));
    end

    // N=4 instance: largest magnitude products must not wrap.
    sel4 = 1'b1;
    for (int r = 0; r < 4; r++) wr(A_WGT, 32'h8080_8080);
    wr(A_IN, 32'h8080_8080);
    wr(A_CTRL, 32'h1);
    wait_done(c);
    chk("n4_latency", c, 1 + 8);
    for (int i = 0; i < 4; i++) begin
      rd(A_RES, q);
      chk("n4_no_wrap", q, 32'h0001_0000);
    end
    sel4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
